button_step_gen: RTL and testbench

- Front-end that converts raw, bouncing, active-low push-button levels into clean step strobes and an acceleration flag.
- Produces the Up/Down/Accel stimulus that the alarm-clock core consumes. It is the driving end of the button interface, the counterpart of the clock's time-setting input logic.
- Handles per-key synchronisation, debounce, hold-to-repeat with a two-speed repeat rate, and mutual exclusion of Up and Down.

---
 rtl/button_step_gen.sv | 150 +++++++++++++++
 tb/tb_button_step_gen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_step_gen.sv
// Debounced Up/Down push-button front-end: per-key sync, debounce, hold-to-repeat
// with two-speed acceleration, and an Up/Down interlock.
module button_step_gen #(
  parameter int unsigned DEBOUNCE_CYC     = 500000,
  parameter int unsigned REPEAT_DELAY_CYC = 25000000,
  parameter int unsigned REPEAT_SLOW_CYC  = 10000000,
  parameter int unsigned REPEAT_FAST_CYC  = 2500000,
  parameter int unsigned FAST_AFTER       = 8,
  parameter int unsigned CNT_W            = 25
) (
  input  logic Clk_50MHz,
  input  logic Rst,
  input  logic Key_Up_n,
  input  logic Key_Down_n,
  output logic Up_Step,
  output logic Down_Step,
  output logic Accel,
  output logic Key_Held
);

  localparam int unsigned RW = (FAST_AFTER > 1) ? $clog2(FAST_AFTER + 1) : 1;

  localparam logic [CNT_W-1:0] DEB_END  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] DLY_END  = CNT_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] SLOW_END = CNT_W'(REPEAT_SLOW_CYC - 1);
  localparam logic [CNT_W-1:0] FAST_END = CNT_W'(REPEAT_FAST_CYC - 1);
  localparam logic [RW-1:0]    FA_V     = RW'(FAST_AFTER);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HELD_DELAY,
    REPEAT,
    DEB_RELEASE
  } state_t;

  // Index 0 is the Up key, index 1 the Down key.
  logic [1:0]       sync1, sync2;
  state_t           state    [2];
  state_t           state_nx [2];
  logic [CNT_W-1:0] timer    [2];
  logic [CNT_W-1:0] timer_nx [2];
  logic [RW-1:0]    rcnt     [2];
  logic [RW-1:0]    rcnt_nx  [2];
  logic [1:0]       fsm_stb, done, held, fast;
  logic             lock, lock_nx, conflict;

  always_ff @(posedge Clk_50MHz) begin
    if (Rst) begin
      sync1 <= '1;
      sync2 <= '1;
      lock  <= 1'b0;
      for (int unsigned k = 0; k < 2; k++) begin
        state[k] <= IDLE;
        timer[k] <= '0;
        rcnt[k]  <= '0;
      end
    end else begin
      sync1 <= {Key_Down_n, Key_Up_n};
      sync2 <= sync1;
      lock  <= lock_nx;
      for (int unsigned k = 0; k < 2; k++) begin
        state[k] <= state_nx[k];
        timer[k] <= timer_nx[k];
        rcnt[k]  <= rcnt_nx[k];
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < 2; k++) begin
      state_nx[k] = state[k];
      timer_nx[k] = timer[k] + CNT_W'(1);
      rcnt_nx[k]  = rcnt[k];
      fsm_stb[k]  = 1'b0;
      done[k]     = 1'b0;
      fast[k]     = 1'b0;
      held[k]     = 1'b0;
      unique case (state[k])
        IDLE: begin
          timer_nx[k] = '0;
          if (!sync2[k]) state_nx[k] = DEB_PRESS;
        end
        DEB_PRESS: begin
          if (sync2[k]) begin
            state_nx[k] = IDLE;
            timer_nx[k] = '0;
          end else if (timer[k] == DEB_END) begin
            state_nx[k] = HELD_DELAY;
            timer_nx[k] = '0;
            done[k]     = 1'b1;
            fsm_stb[k]  = 1'b1;
          end
        end
        HELD_DELAY: begin
          held[k] = 1'b1;
          if (sync2[k]) begin
            state_nx[k] = DEB_RELEASE;
            timer_nx[k] = '0;
          end else if (timer[k] == DLY_END) begin
            state_nx[k] = REPEAT;
            timer_nx[k] = '0;
            rcnt_nx[k]  = RW'(1);
            fsm_stb[k]  = 1'b1;
          end
        end
        REPEAT: begin
          held[k] = 1'b1;
          fast[k] = (rcnt[k] == FA_V);
          if (sync2[k]) begin
            state_nx[k] = DEB_RELEASE;
            timer_nx[k] = '0;
          end else if (timer[k] == ((rcnt[k] == FA_V) ? FAST_END : SLOW_END)) begin
            timer_nx[k] = '0;
            fsm_stb[k]  = 1'b1;
            if (rcnt[k] != FA_V) rcnt_nx[k] = rcnt[k] + RW'(1);
            // Accel rises together with the strobe that completes the slow phase.
            fast[k] = (rcnt_nx[k] == FA_V);
          end
        end
        DEB_RELEASE: begin
          held[k] = 1'b1;
          if (!sync2[k]) begin
            state_nx[k] = HELD_DELAY;
            timer_nx[k] = '0;
          end else if (timer[k] == DEB_END) begin
            state_nx[k] = IDLE;
            timer_nx[k] = '0;
          end
        end
        default: begin
          state_nx[k] = IDLE;
          timer_nx[k] = '0;
        end
      endcase
    end
  end

  // A key finishing debounce while the other is already pressed (or on the same
  // cycle) locks both out until both FSMs are back in IDLE.
  always_comb begin
    conflict  = (done[0] && (done[1] || held[1])) || (done[1] && (done[0] || held[0]));
    lock_nx   = conflict || (lock && !((state[0] == IDLE) && (state[1] == IDLE)));
    Up_Step   = fsm_stb[0] && !lock && !conflict;
    Down_Step = fsm_stb[1] && !lock && !conflict;
    Accel     = (fast[0] || fast[1]) && !lock;
    Key_Held  = |held || |done;
  end

endmodule

// File: tb/tb_button_step_gen.sv
// Self-checking bench for button_step_gen: stimulus/expectation vector tables
// plus a strobe scoreboard filled when stimulus is driven.
module tb_button_step_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, up_n, down_n;
  logic up_step, down_step, accel, key_held;

  button_step_gen #(
    .DEBOUNCE_CYC    (4),
    .REPEAT_DELAY_CYC(20),
    .REPEAT_SLOW_CYC (8),
    .REPEAT_FAST_CYC (3),
    .FAST_AFTER      (2),
    .CNT_W           (25)
  ) dut (
    .Clk_50MHz (clk),
    .Rst       (rst),
    .Key_Up_n  (up_n),
    .Key_Down_n(down_n),
    .Up_Step   (up_step),
    .Down_Step (down_step),
    .Accel     (accel),
    .Key_Held  (key_held)
  );

  typedef struct {
    int unsigned at;
    logic        up;
    logic        down;
  } stb_t;

  typedef struct {
    int unsigned off;
    logic        up_n;
    logic        down_n;
    logic        chk;
    logic        accel;
    logic        held;
  } vec_t;

  stb_t        exp_q[$];
  vec_t        vq[$];
  int unsigned cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  string       tname = "reset";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s at cycle %0d: got %0h, expected %0h", tname, name, cyc, act, exp);
    end
  endtask

  // One clock: sample at the falling edge and retire scoreboard entries.
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
      n_assert++;
      n_fail++;
      $display("FAIL %s/strobe_missing: expected up=%0b down=%0b at cycle %0d, no strobe observed",
               tname, exp_q[0].up, exp_q[0].down, exp_q[0].at);
      void'(exp_q.pop_front());
    end
    if (up_step || down_step) begin
      if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
        stb_t e;
        e = exp_q.pop_front();
        check("strobe_kind", {up_step, down_step}, {e.up, e.down});
      end else begin
        check("unexpected_strobe", {up_step, down_step}, 2'b00);
      end
    end
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc < t) tick();
  endtask

  function automatic void push(input logic up, input logic dn, input int unsigned at);
    stb_t s;
    s.at = at; s.up = up; s.down = dn;
    exp_q.push_back(s);
  endfunction

  function automatic void row(input int unsigned off, input logic un, input logic dn,
                              input logic chk, input logic acc, input logic hld);
    vec_t r;
    r.off = off; r.up_n = un; r.down_n = dn; r.chk = chk; r.accel = acc; r.held = hld;
    vq.push_back(r);
  endfunction

  // Each row: at its offset, check the levels (if chk) and then apply its inputs.
  task automatic run_vecs(input int unsigned t0);
    foreach (vq[i]) begin
      wait_until(t0 + vq[i].off);
      if (vq[i].chk) begin
        check("accel", accel, vq[i].accel);
        check("key_held", key_held, vq[i].held);
      end
      up_n   = vq[i].up_n;
      down_n = vq[i].down_n;
    end
    vq.delete();
  endtask

  initial begin
    int unsigned t0;
    rst = 1'b1; up_n = 1'b1; down_n = 1'b1;
    repeat (3) tick();
    check("up_step", up_step, 1'b0);
    check("down_step", down_step, 1'b0);
    check("accel", accel, 1'b0);
    check("key_held", key_held, 1'b0);
    rst = 1'b0;
    repeat (5) tick();

    tname = "single_press";
    t0 = cyc;
    push(1'b1, 1'b0, t0 + 6);
    row(0, 0, 1, 0, 0, 0);
    row(5, 0, 1, 1, 0, 0);
    row(6, 0, 1, 1, 0, 1);
    row(10, 1, 1, 1, 0, 1);
    row(16, 1, 1, 1, 0, 1);
    row(17, 1, 1, 1, 0, 0);
    row(25, 1, 1, 0, 0, 0);
    run_vecs(t0);

    tname = "bounce_reject";
    t0 = cyc;
    for (int unsigned i = 0; i <= 20; i += 2) row(i, 1, (i % 4 == 2 || i == 20) ? 1'b1 : 1'b0, 1, 0, 0);
    row(30, 1, 1, 1, 0, 0);
    run_vecs(t0);
    tname = "down_after_bounce";
    t0 = cyc;
    push(1'b0, 1'b1, t0 + 6);
    row(0, 1, 0, 0, 0, 0);
    row(6, 1, 0, 1, 0, 1);
    row(8, 1, 1, 1, 0, 1);
    row(30, 1, 1, 1, 0, 0);
    run_vecs(t0);

    tname = "hold_accel";
    t0 = cyc;
    push(1'b1, 1'b0, t0 + 6);
    push(1'b1, 1'b0, t0 + 26);
    push(1'b1, 1'b0, t0 + 34);
    for (int unsigned o = 37; o <= 79; o += 3) push(1'b1, 1'b0, t0 + o);
    row(0, 0, 1, 0, 0, 0);
    row(33, 0, 1, 1, 0, 1);
    row(34, 0, 1, 1, 1, 1);
    row(35, 0, 1, 1, 1, 1);
    row(60, 0, 1, 1, 1, 1);
    row(80, 1, 1, 1, 1, 1);
    row(82, 1, 1, 1, 1, 1);
    row(83, 1, 1, 1, 0, 1);
    row(86, 1, 1, 1, 0, 1);
    row(87, 1, 1, 1, 0, 0);
    row(100, 1, 1, 0, 0, 0);
    run_vecs(t0);

    tname = "release_bounce";
    t0 = cyc;
    push(1'b1, 1'b0, t0 + 6);
    row(0, 0, 1, 0, 0, 0);
    row(8, 1, 1, 1, 0, 1);
    row(12, 0, 1, 0, 0, 0);
    row(13, 1, 1, 0, 0, 0);
    row(14, 1, 1, 1, 0, 1);
    row(15, 1, 1, 1, 0, 1);
    row(16, 0, 1, 1, 0, 1);
    row(17, 1, 1, 0, 0, 0);
    row(19, 1, 1, 1, 0, 1);
    row(23, 1, 1, 1, 0, 1);
    row(24, 1, 1, 1, 0, 0);
    row(30, 1, 1, 0, 0, 0);
    run_vecs(t0);

    tname = "interlock";
    t0 = cyc;
    push(1'b1, 1'b0, t0 + 6);
    push(1'b1, 1'b0, t0 + 66);
    row(0, 0, 1, 0, 0, 0);
    row(10, 0, 0, 0, 0, 0);
    row(16, 0, 0, 1, 0, 1);
    row(26, 0, 0, 1, 0, 1);
    row(34, 0, 0, 1, 0, 1);
    row(38, 0, 0, 1, 0, 1);
    row(40, 1, 0, 1, 0, 1);
    row(44, 1, 0, 1, 0, 1);
    row(48, 1, 0, 1, 0, 1);
    row(50, 1, 1, 1, 0, 1);
    row(52, 1, 1, 1, 0, 1);
    row(56, 1, 1, 1, 0, 1);
    row(57, 1, 1, 1, 0, 0);
    row(60, 0, 1, 0, 0, 0);
    row(66, 0, 1, 1, 0, 1);
    row(70, 1, 1, 0, 0, 0);
    row(90, 1, 1, 0, 0, 0);
    run_vecs(t0);

    tname = "same_cycle_lock";
    t0 = cyc;
    push(1'b0, 1'b1, t0 + 46);
    row(0, 0, 0, 0, 0, 0);
    row(6, 0, 0, 1, 0, 1);
    row(20, 0, 0, 1, 0, 1);
    row(30, 1, 1, 1, 0, 1);
    row(37, 1, 1, 1, 0, 0);
    row(40, 1, 0, 0, 0, 0);
    row(50, 1, 1, 0, 0, 0);
    row(70, 1, 1, 0, 0, 0);
    run_vecs(t0);

    tname = "reset_mid_hold";
    t0 = cyc;
    push(1'b1, 1'b0, t0 + 6);
    push(1'b1, 1'b0, t0 + 26);
    push(1'b1, 1'b0, t0 + 34);
    row(0, 0, 1, 0, 0, 0);
    row(36, 0, 1, 1, 1, 1);
    run_vecs(t0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("up_step", up_step, 1'b0);
    check("down_step", down_step, 1'b0);
    check("accel", accel, 1'b0);
    check("key_held", key_held, 1'b0);
    push(1'b1, 1'b0, t0 + 43);
    row(42, 0, 1, 1, 0, 0);
    row(43, 0, 1, 1, 0, 1);
    row(50, 1, 1, 0, 0, 0);
    row(70, 1, 1, 1, 0, 0);
    run_vecs(t0);

    tname = "final";
    repeat (5) tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
